// File: rtl/ov7670_reg_sequencer_if.sv
// ov7670_reg_sequencer_if: command handshake between the register sequencer and i2c_sender
interface ov7670_reg_sequencer_if;
    logic       send;
    logic       taken;
    logic [7:0] id;
    logic [7:0] reg_addr;
    logic [7:0] value;
    modport master (output send, id, reg_addr, value, input taken);
    modport slave  (input send, id, reg_addr, value, output taken);
endinterface

// File: rtl/ov7670_reg_sequencer.sv
// ov7670_reg_sequencer: walks the OV7670 register table and feeds {id, reg_addr, value} commands to i2c_sender.
// Optional SEND watchdog with sticky cfg_error output is enabled by defining OV7670_SEQ_TIMEOUT_EN.
module ov7670_reg_sequencer #(
    parameter logic [7:0] DEVICE_ID     = 8'h42,
    parameter int         CYCLES_PER_MS = 25000,
    parameter logic [7:0] POWERUP_MS    = 8'd1,
    parameter int         TABLE_DEPTH   = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          resend,
    ov7670_reg_sequencer_if.master        bus,
    output logic                          config_done,
`ifdef OV7670_SEQ_TIMEOUT_EN
    output logic                          cfg_error,
`endif
    output logic                          busy
);
    localparam int IW = $clog2(TABLE_DEPTH);
    localparam int CW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;

    typedef enum logic [2:0] {POWERUP, FETCH, SEND, DELAY, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    ms_q, ms_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          send_q, send_d;
    logic [7:0]    reg_addr_q, reg_addr_d;
    logic [7:0]    value_q, value_d;
    logic          config_done_q, config_done_d;
    logic [15:0]   entry;
`ifdef OV7670_SEQ_TIMEOUT_EN
    logic [23:0]   wd_q, wd_d;
    logic          cfg_error_q, cfg_error_d;
`endif

    // Register table ROM: 16'hFFFF ends the table, 16'hFExx waits xx ms
    always_comb begin
        case (int'(idx_q))
            0:       entry = 16'h1280;
            1:       entry = 16'hFE0A;
            2:       entry = 16'h1204;
            3:       entry = 16'h40D0;
            4:       entry = 16'h1101;
            5:       entry = 16'hFFFF;
            6:       entry = 16'h3A04;
            7:       entry = 16'h3DC8;
            8:       entry = 16'h1400;
            9:       entry = 16'hFFFF;
            default: entry = 16'hFFFF;
        endcase
    end

    // Next-state and output logic; resend overrides everything, including a same-cycle taken
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ms_d          = ms_q;
        cyc_d         = cyc_q;
        send_d        = send_q;
        reg_addr_d    = reg_addr_q;
        value_d       = value_q;
        config_done_d = config_done_q;
`ifdef OV7670_SEQ_TIMEOUT_EN
        wd_d          = wd_q;
        cfg_error_d   = cfg_error_q;
`endif
        if (resend) begin
            state_d       = POWERUP;
            idx_d         = '0;
            ms_d          = POWERUP_MS;
            cyc_d         = '0;
            send_d        = 1'b0;
            config_done_d = 1'b0;
`ifdef OV7670_SEQ_TIMEOUT_EN
            cfg_error_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                POWERUP, DELAY: begin
                    if (ms_q == 8'd0) begin
                        state_d = FETCH;
                    end else if (cyc_q == CW'(CYCLES_PER_MS - 1)) begin
                        cyc_d = '0;
                        ms_d  = ms_q - 8'd1;
                        if (ms_q == 8'd1) state_d = FETCH;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                FETCH: begin
                    if (entry == 16'hFFFF || idx_q == IW'(TABLE_DEPTH - 1)) begin
                        state_d       = DONE;
                        send_d        = 1'b0;
                        config_done_d = 1'b1;
                    end else if (entry[15:8] == 8'hFE) begin
                        idx_d = idx_q + IW'(1);
                        ms_d  = entry[7:0];
                        cyc_d = '0;
                        if (entry[7:0] != 8'd0) state_d = DELAY;
                    end else begin
                        reg_addr_d = entry[15:8];
                        value_d    = entry[7:0];
                        send_d     = 1'b1;
                        state_d    = SEND;
`ifdef OV7670_SEQ_TIMEOUT_EN
                        wd_d       = '0;
`endif
                    end
                end
                SEND: begin
                    if (bus.taken) begin
                        send_d  = 1'b0;
                        idx_d   = idx_q + IW'(1);
                        state_d = FETCH;
`ifdef OV7670_SEQ_TIMEOUT_EN
                    end else if (wd_q == 24'hFFFFFE) begin
                        send_d      = 1'b0;
                        cfg_error_d = 1'b1;
                        idx_d       = idx_q + IW'(1);
                        state_d     = FETCH;
                    end else begin
                        wd_d = wd_q + 24'd1;
`endif
                    end
                end
                DONE: begin
                    send_d        = 1'b0;
                    config_done_d = 1'b1;
                end
                default: state_d = DONE;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= POWERUP;
            idx_q         <= '0;
            ms_q          <= POWERUP_MS;
            cyc_q         <= '0;
            send_q        <= 1'b0;
            reg_addr_q    <= 8'hFF;
            value_q       <= 8'hFF;
            config_done_q <= 1'b0;
`ifdef OV7670_SEQ_TIMEOUT_EN
            wd_q          <= '0;
            cfg_error_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ms_q          <= ms_d;
            cyc_q         <= cyc_d;
            send_q        <= send_d;
            reg_addr_q    <= reg_addr_d;
            value_q       <= value_d;
            config_done_q <= config_done_d;
`ifdef OV7670_SEQ_TIMEOUT_EN
            wd_q          <= wd_d;
            cfg_error_q   <= cfg_error_d;
`endif
        end
    end

    assign bus.send     = send_q;
    assign bus.id       = DEVICE_ID;
    assign bus.reg_addr = reg_addr_q;
    assign bus.value    = value_q;
    assign config_done  = config_done_q;
    assign busy         = (state_q != DONE);
`ifdef OV7670_SEQ_TIMEOUT_EN
    assign cfg_error    = cfg_error_q;
`endif

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// tb_ov7670_reg_sequencer: randomized sender model checked against a table-walk reference
module tb_ov7670_reg_sequencer;
    localparam int CPM = 4;
    localparam int PWR = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic resend = 1'b0;
    logic config_done;
    logic busy;
`ifdef OV7670_SEQ_TIMEOUT_EN
    logic cfg_error;
`endif

    ov7670_reg_sequencer_if bus();

    ov7670_reg_sequencer #(
        .DEVICE_ID    (8'h42),
        .CYCLES_PER_MS(CPM),
        .POWERUP_MS   (8'(PWR)),
        .TABLE_DEPTH  (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .resend     (resend),
        .bus        (bus),
        .config_done(config_done),
`ifdef OV7670_SEQ_TIMEOUT_EN
        .cfg_error  (cfg_error),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] tbl [6] = '{16'h1280, 16'hFE0A, 16'h1204, 16'h40D0, 16'h1101, 16'hFFFF};
    int exp_addr[$];
    int exp_val[$];
    int exp_gap[$];
    int done_gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the table, turning delay markers into low-send cycles before each write
    task automatic build_model;
        int acc = PWR * CPM;
        done_gap = 0;
        for (int i = 0; i < 6; i++) begin
            if (tbl[i] == 16'hFFFF) begin
                done_gap = acc + 1;
                break;
            end else if (tbl[i][15:8] == 8'hFE) begin
                acc += 1 + int'(tbl[i][7:0]) * CPM;
            end else begin
                exp_addr.push_back(int'(tbl[i][15:8]));
                exp_val.push_back(int'(tbl[i][7:0]));
                exp_gap.push_back(acc + 1);
                acc = 0;
            end
        end
    endtask

    task automatic wait_send(input int gap, input bit stray);
        int n = 0;
        while (bus.send !== 1'b1 && n < 200) begin
            bus.taken = stray && ($urandom_range(0, 3) == 0);
            tick;
            n++;
        end
        bus.taken = 1'b0;
        check("send_gap", n, gap);
    endtask

    task automatic serve(input int k, input int hold);
        wait_send(exp_gap[k], 1'b1);
        check("addr", bus.reg_addr, exp_addr[k]);
        check("value", bus.value, exp_val[k]);
        check("id", bus.id, 8'h42);
        check("busy_send", busy, 1'b1);
        repeat (hold) begin
            tick;
            check("hold_send", bus.send, 1'b1);
            check("hold_addr", bus.reg_addr, exp_addr[k]);
            check("hold_value", bus.value, exp_val[k]);
        end
        bus.taken = 1'b1;
        tick;
        bus.taken = 1'b0;
        check("send_drop", bus.send, 1'b0);
    endtask

    task automatic expect_done;
        repeat (done_gap - 1) tick;
        check("done_early", config_done, 1'b0);
        tick;
        check("config_done", config_done, 1'b1);
        check("busy_done", busy, 1'b0);
        check("send_done", bus.send, 1'b0);
    endtask

    initial begin
        build_model;
        bus.taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_send", bus.send, 1'b0);
        check("rst_addr", bus.reg_addr, 8'hFF);
        check("rst_value", bus.value, 8'hFF);
        check("rst_done", config_done, 1'b0);
        check("rst_busy", busy, 1'b1);
        reset_n = 1'b1;
        for (int k = 0; k < exp_addr.size(); k++) serve(k, (k == 1) ? 500 : 2);
        expect_done;
        repeat (30) begin
            bus.taken = 1'($urandom_range(0, 1));
            tick;
        end
        bus.taken = 1'b0;
        check("no_fifth_send", bus.send, 1'b0);
        check("done_sticky", config_done, 1'b1);
        resend = 1'b1;
        tick;
        resend = 1'b0;
        check("resend_done_drop", config_done, 1'b0);
        check("resend_busy", busy, 1'b1);
        serve(0, $urandom_range(1, 6));
        repeat ($urandom_range(2, 30)) begin
            bus.taken = 1'($urandom_range(0, 1));
            tick;
        end
        check("delay_send_low", bus.send, 1'b0);
        resend = 1'b1;
        bus.taken = 1'b1;
        tick;
        resend = 1'b0;
        bus.taken = 1'b0;
        check("resend_delay_busy", busy, 1'b1);
        check("resend_delay_send", bus.send, 1'b0);
        wait_send(exp_gap[0], 1'b1);
        check("restart_addr", bus.reg_addr, exp_addr[0]);
        resend = 1'b1;
        bus.taken = 1'b1;
        tick;
        resend = 1'b0;
        bus.taken = 1'b0;
        check("resend_taken_send", bus.send, 1'b0);
        for (int k = 0; k < exp_addr.size(); k++) serve(k, $urandom_range(1, 6));
        expect_done;
        resend = 1'b1;
        tick;
        resend = 1'b0;
        wait_send(exp_gap[0], 1'b0);
        reset_n = 1'b0;
        #1;
        check("async_send", bus.send, 1'b0);
        check("async_addr", bus.reg_addr, 8'hFF);
        check("async_value", bus.value, 8'hFF);
        check("async_busy", busy, 1'b1);
        tick;
        reset_n = 1'b1;
        serve(0, 2);
        serve(1, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
